// File: rtl/data_sram_responder_if.sv
// CPU data-port bundle between the pipeline (master) and the data SRAM responder (slave).
// One request outstanding at a time: addr_ok accepts, data_ok returns the response.
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Single-outstanding data SRAM responder: data_ok LATENCY cycles after accept, addr_ok low while busy.
// Optional DSRAM_ALIGN_CHECK_EN flags misaligned/reserved-size accesses with err instead of aligning down.
module data_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  data_sram_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;
  logic            wr_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [0:(1<<AW)-1];

  logic            in_idle;
  logic            enter_resp;
  logic            s_wr;
  logic [AW-1:0]   s_idx;
  logic            s_fault;
  logic            fault_q;
  logic [AW-1:0]   w_idx;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     mask;
  logic [31:0]     merged;
  logic            do_write;
  logic            data_ok_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            unused_addr;

  assign unused_addr = ^bus.addr[31:AW+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_idle     = (state == IDLE);
  assign enter_resp  = (state_nxt == RESP);
  assign bus.addr_ok = in_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= bus.wr;
      size_q  <= bus.size;
      addr_q  <= bus.addr[AW+1:0];
      wdata_q <= bus.wdata;
    end
  end

  // With LATENCY=1 the response is formed on the accept edge, so take the live request then.
  assign s_wr  = in_idle ? bus.wr : wr_q;
  assign s_idx = in_idle ? bus.addr[AW+1:2] : addr_q[AW+1:2];

`ifdef DSRAM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00) || (sz == 2'b11);
  endfunction
  assign fault_q = misaligned(size_q, addr_q[1:0]);
  assign s_fault = in_idle ? misaligned(bus.size, bus.addr[1:0]) : fault_q;
`else
  assign fault_q = 1'b0;
  assign s_fault = 1'b0;
`endif

  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (size_q)
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  assign w_idx    = addr_q[AW+1:2];
  assign mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged   = (mem[w_idx] & ~mask) | (wd & mask);
  assign do_write = (state == RESP) && wr_q && !fault_q;

  // Store commits on the edge that ends RESP; an async reset before then drops it.
  always_ff @(posedge clk) begin
    if (do_write) mem[w_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      data_ok_q <= enter_resp;
      err_q     <= enter_resp && s_fault;
      rdata_q   <= (enter_resp && !s_wr && !s_fault) ? mem[s_idx] : '0;
    end
  end

  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder at LATENCY 2, plus LATENCY 1 and 15 throughput instances.
module tb_data_sram_responder;

  localparam int LAT = 2;
`ifdef DSRAM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  data_sram_responder_if dbus ();
  data_sram_responder_if lb1 ();
  data_sram_responder_if lb15 ();

  data_sram_responder #(.AW(10), .LATENCY(LAT)) u_dut  (.clk(clk), .rst(rst_n), .bus(dbus));
  data_sram_responder #(.AW(10), .LATENCY(1))   u_l1   (.clk(clk), .rst(rst_n), .bus(lb1));
  data_sram_responder #(.AW(10), .LATENCY(15))  u_l15  (.clk(clk), .rst(rst_n), .bus(lb15));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] model [0:1023];

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN_CHK && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || sz == 2'd3);
  endfunction

  always @(negedge clk) begin
    if (rst_n && dbus.data_ok) begin
      if (sb.size() == 0) begin
        chk("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(got.cyc));
        chk("rdata", dbus.rdata, got.rdata);
        chk("err", {31'd0, dbus.err}, {31'd0, got.err});
      end
    end
  end

  task automatic acc(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic        f;
    logic [9:0]  wi;
    logic [31:0] exp_rd;
    exp_t        ex;
    n  = 0;
    f  = model_fault(sz, a);
    wi = a[11:2];
    if (w && !f) begin
      case (sz)
        2'd0:    model[wi][8*a[1:0] +: 8] = d[7:0];
        2'd1:    model[wi][16*a[1] +: 16] = d[15:0];
        default: model[wi] = d;
      endcase
    end
    exp_rd = (w || f) ? 32'd0 : model[wi];
    @(posedge clk); #1;
    dbus.req = 1'b1; dbus.wr = w; dbus.size = sz; dbus.addr = a; dbus.wdata = d;
    @(negedge clk);
    while (!dbus.addr_ok && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept_wait", 32'(n), 32'd0);
    if (!dbus.addr_ok) begin
      dbus.req = 1'b0;
      return;
    end
    ex.rdata = exp_rd;
    ex.err   = f;
    ex.cyc   = cyc + LAT;
    sb.push_back(ex);
    @(posedge clk); #1;
    // Scramble the request lines; the DUT must use what it latched.
    dbus.req = 1'b0; dbus.wr = 1'($urandom); dbus.size = 2'($urandom);
    dbus.addr = $urandom; dbus.wdata = $urandom;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("addr_ok_busy", {31'd0, dbus.addr_ok}, 32'd0);
    end
  endtask

  int lq1[$], lq15[$];
  int last1 = -1, last15 = -1, n15 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lq1.delete();
      last1 = -1;
    end else begin
      if (lb1.data_ok) begin
        if (lq1.size() == 0) chk("l1_spurious", 32'd1, 32'd0);
        else chk("l1_rsp_cycle", 32'(cyc), 32'(lq1.pop_front()));
      end
      if (lb1.req && lb1.addr_ok) begin
        if (last1 >= 0) chk("l1_accept_gap", 32'(cyc - last1), 32'd2);
        lq1.push_back(cyc + 1);
        last1 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      lq15.delete();
      last15 = -1;
    end else begin
      if (lb15.data_ok) begin
        if (lq15.size() == 0) chk("l15_spurious", 32'd1, 32'd0);
        else chk("l15_rsp_cycle", 32'(cyc), 32'(lq15.pop_front()));
      end
      if (lb15.req && lb15.addr_ok) begin
        if (last15 >= 0) chk("l15_accept_gap", 32'(cyc - last15), 32'd16);
        lq15.push_back(cyc + 15);
        last15 = cyc;
        n15++;
      end
    end
  end

  initial begin
    int          ndok;
    logic [31:0] a;
    rst_n = 1'b0;
    dbus.req = 1'b0; dbus.wr = 1'b0; dbus.size = 2'd0; dbus.addr = '0; dbus.wdata = '0;
    lb1.req = 1'b0;  lb1.wr = 1'b0;  lb1.size = 2'd2;  lb1.addr = '0;  lb1.wdata = '0;
    lb15.req = 1'b0; lb15.wr = 1'b0; lb15.size = 2'd2; lb15.addr = '0; lb15.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr_ok", {31'd0, dbus.addr_ok}, 32'd1);
    chk("rst_data_ok", {31'd0, dbus.data_ok}, 32'd0);
    chk("rst_rdata", dbus.rdata, 32'd0);
    chk("rst_err", {31'd0, dbus.err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    acc(1'b1, 2'd2, 32'h40, 32'hDEADBEEF);
    acc(1'b0, 2'd2, 32'h40, 32'h0);

    acc(1'b1, 2'd2, 32'h80, 32'h0);
    acc(1'b1, 2'd0, 32'h81, 32'hFFFF_FFAA);
    acc(1'b1, 2'd1, 32'h82, 32'hFFFF_1234);
    acc(1'b0, 2'd2, 32'h80, 32'h0);
    acc(1'b0, 2'd2, 32'hABC0_0080, 32'h0);

    // Abort a store of 0x55 to 0x10 with reset during WAIT.
    acc(1'b1, 2'd2, 32'h10, 32'h11);
    @(posedge clk); #1;
    dbus.req = 1'b1; dbus.wr = 1'b1; dbus.size = 2'd2; dbus.addr = 32'h10; dbus.wdata = 32'h55;
    @(negedge clk);
    chk("abort_accept", {31'd0, dbus.addr_ok}, 32'd1);
    @(posedge clk); #1;
    dbus.req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_addr_ok", {31'd0, dbus.addr_ok}, 32'd1);
    chk("abort_rst_data_ok", {31'd0, dbus.data_ok}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndok = 0;
    repeat (6) begin
      @(negedge clk);
      if (dbus.data_ok) ndok++;
    end
    chk("abort_no_rsp", 32'(ndok), 32'd0);
    acc(1'b0, 2'd2, 32'h10, 32'h0);

    acc(1'b1, 2'd2, 32'h42, 32'hCAFEF00D);
    acc(1'b0, 2'd2, 32'h40, 32'h0);
    acc(1'b1, 2'd1, 32'h83, 32'h0000_5A5A);
    acc(1'b1, 2'd3, 32'h84, 32'h1357_9BDF);
    acc(1'b0, 2'd2, 32'h80, 32'h0);
    acc(1'b0, 2'd3, 32'h84, 32'h0);

    for (int i = 0; i < 16; i++) acc(1'b1, 2'd2, 32'h200 + 32'(4 * i), $urandom);
    for (int i = 0; i < 24; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 63));
      acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    @(posedge clk); #1;
    lb1.req = 1'b1;
    lb15.req = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    lb1.req = 1'b0;
    lb15.req = 1'b0;
    repeat (20) @(negedge clk);
    chk("l1_drain", 32'(lq1.size()), 32'd0);
    chk("l15_drain", 32'(lq15.size()), 32'd0);
    chk("l15_accepts_seen", {31'd0, n15 >= 3}, 32'd1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the pipeline's data port: accepts one load/store request at a time from the CPU data interface, services it against an internal word-organised SRAM after a fixed, parameterised latency, and returns a one-cycle `data_ok` pulse with read data. It sits below the MEM stage and drives the stall condition the pipeline uses while a memory access is outstanding. Byte, halfword and word stores are merged into the addressed word; loads always return the full aligned word, and the CPU performs lane extraction.

## Interface
- `AW`, 10: word-address width; memory depth is 2^AW words.
- `LATENCY`, 2: cycles from the accept cycle to the `data_ok` cycle; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req` input 1: request valid.
- `wr` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `addr` input 32: byte address; bits [AW+1:2] index memory, upper bits ignored.
- `wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `addr_ok` output 1: request accepted this cycle when `req` is also high.
- `data_ok` output 1: one-cycle response pulse.
- `rdata` output 32: aligned word read; valid only while `data_ok` is high.
- `err` output 1: access fault, valid with `data_ok` (see Configuration).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `addr_ok`=1. On `req`=1, latch `wr`, `size`, `addr`, `wdata` and load the counter with LATENCY-1.
  - If LATENCY=1, go to RESP.
  - Otherwise go to WAIT.
- WAIT: `addr_ok`=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP.
- RESP: `data_ok`=1 for exactly this cycle, then return to IDLE. `addr_ok`=0 in RESP, so no request is accepted in the same cycle as a response.
- Load: `rdata` is the memory word at the latched index, read in the RESP cycle.
- Store: the write commits at the rising edge that ends the RESP cycle. `rdata` is 0 for stores.
- Store lane merge:
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Word: all four lanes are written.
- Request inputs are sampled only in the accept cycle. Changes to them afterwards are ignored.
- Memory contents are not reset.
- Reset asserted mid-transaction:
  - The in-flight access is dropped and a pending store is not committed.
  - State returns to IDLE.
  - No `data_ok` is emitted for the dropped access.

## Timing
- Reset values: state IDLE, `addr_ok`=1, `data_ok`=0, `rdata`=0, `err`=0, counter 0.
- Throughput is one access per LATENCY+1 cycles.
- With acceptance in cycle N, `data_ok` is high in cycle N+LATENCY and `addr_ok` is high again in cycle N+LATENCY+1.
- `addr_ok` is a function of state only (registered state). It has no combinational path from `req`.
- `data_ok`, `rdata` and `err` are registered outputs.
- Store followed by a load to the same address: the load, accepted at N+LATENCY+1, returns the newly written data.

## Configuration
- `DSRAM_ALIGN_CHECK_EN` defined:
  - Each access is checked for faults: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11.
  - A faulting access still completes with normal latency, with `err`=1 and `rdata`=0 in the RESP cycle.
  - A faulting store writes nothing.
- `DSRAM_ALIGN_CHECK_EN` not defined:
  - `err` is tied to 0.
  - Misaligned addresses are aligned down: half to `addr[1]`, word to the whole word.
  - `size`=11 is treated as a word access.

## Test plan
- Reset then word store:
  - Stimulus: rst low→high, LATENCY=2; store word 0xDEADBEEF to 0x40 accepted at cycle 0.
  - Response: `data_ok` in cycle 2 only; `addr_ok` low in cycles 1–2; a load of 0x40 returns 0xDEADBEEF.
- Byte/half merge:
  - Stimulus: store word 0 to 0x80, store byte 0xAA to 0x81, store half 0x1234 to 0x82, then load 0x80.
  - Response: `rdata`=0x1234AA00.
- Latency sweep:
  - Stimulus: LATENCY=1 and LATENCY=15.
  - Response: `data_ok` exactly 1 and 15 cycles after acceptance; `req` held high continuously is accepted once per LATENCY+1 cycles.
- Input hold-off:
  - Stimulus: change `addr`/`wdata` during WAIT.
  - Response: the response and the write use the values latched at acceptance.
- Reset mid-store:
  - Stimulus: assert rst during WAIT of a store of 0x55 to 0x10 whose location previously held 0x11.
  - Response: no `data_ok`; a later load of 0x10 returns 0x11.
- Alignment fault (`DSRAM_ALIGN_CHECK_EN` defined):
  - Stimulus: word store to 0x42.
  - Response: `err`=1 with `data_ok` and the memory word is unchanged.
  - Without the macro: the same store writes word 0x40 and `err`=0.
